// File: rtl/req_encoder4to2_pkg.sv
// Shared definitions for the 4-to-2 request encoder: widths, FSM state
// encoding and small bit-vector helpers used by the encoder and its
// priority sub-module.
package req_encoder4to2_pkg;

    localparam int unsigned N_REQ  = 4;
    localparam int unsigned CODE_W = 2;

    // Two-state offer machine; explicit encoding keeps the legacy values.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    // One-hot mask for a code, used to retire the granted pending bit.
    function automatic logic [N_REQ-1:0] code_onehot(input logic [CODE_W-1:0] code);
        logic [N_REQ-1:0] mask;
        mask = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (code == CODE_W'(i)) begin
                mask[i] = 1'b1;
            end
        end
        return mask;
    endfunction

    // Number of set bits in a request vector.
    function automatic logic [CODE_W:0] popcount(input logic [N_REQ-1:0] vec);
        logic [CODE_W:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cnt = cnt + {{CODE_W{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/req_encoder4to2_prio_enc4.sv
// Combinational highest-index-wins priority encoder over a 4-bit vector.
// Also reports whether any bit is set and whether two or more are set.
module prio_enc4
    import req_encoder4to2_pkg::*;
(
    input  logic [N_REQ-1:0]  vec,
    output logic [CODE_W-1:0] idx,
    output logic              any,
    output logic              multi
);

    // Scan upward so the highest set index is the last one written.
    always_comb begin
        idx   = '0;
        any   = |vec;
        multi = (popcount(vec) >= (CODE_W + 1)'(2));
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (vec[i]) begin
                idx = CODE_W'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder4to2.sv
// Request encoder: collects request events on D into a pending set and
// offers them one at a time, highest index first, over a valid/ready
// handshake. Repeated requests on a still-pending line raise a sticky ovf.
module req_encoder4to2
    import req_encoder4to2_pkg::*;
#(
    parameter int EDGE_MODE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_REQ-1:0]  D,
    output logic [CODE_W-1:0] A,
    output logic              valid,
    input  logic              ready,
    output logic              multi,
    output logic              ovf,
    input  logic              clr
);

    state_t            state;
    logic [N_REQ-1:0]  d_q;
    logic [N_REQ-1:0]  pend;
    logic [N_REQ-1:0]  ev;
    logic              hs;
    logic [N_REQ-1:0]  hs_clear;
    logic [N_REQ-1:0]  pend_next;
    logic              ovf_set;

    logic [CODE_W-1:0] pend_idx;
    logic              pend_any;
    logic              pend_multi;
    logic [CODE_W-1:0] rem_idx;
    logic              rem_any;
    logic              rem_multi;

    // Offer is visible exactly while the machine sits in OFFER.
    always_comb begin
        valid = (state == OFFER);
    end

    // Event detection, handshake retirement and next pending set.
    always_comb begin
        ev        = (EDGE_MODE != 0) ? (D & ~d_q) : D;
        hs        = valid & ready;
        hs_clear  = hs ? code_onehot(A) : '0;
        // A new event on the line being retired re-arms it rather than
        // being lost, and is not counted as an overflow.
        pend_next = (pend & ~hs_clear) | ev;
        ovf_set   = |(ev & pend & ~hs_clear);
    end

    // Priority on the current pending set feeds the IDLE load.
    prio_enc4 u_prio_pend (
        .vec   (pend),
        .idx   (pend_idx),
        .any   (pend_any),
        .multi (pend_multi)
    );

    // Priority on what remains after a handshake feeds back-to-back reloads.
    prio_enc4 u_prio_rem (
        .vec   (pend_next),
        .idx   (rem_idx),
        .any   (rem_any),
        .multi (rem_multi)
    );

    // Previous D sample for edge detection; keeps running through clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q <= '0;
        end else begin
            d_q <= D;
        end
    end

    // Pending set and sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else if (clr) begin
            pend <= '0;
            ovf  <= 1'b0;
        end else begin
            pend <= pend_next;
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    // Offer state machine holding the granted code and its multi flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            A     <= '0;
            multi <= 1'b0;
        end else if (clr) begin
            state <= IDLE;
            A     <= '0;
            multi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pend_any) begin
                        A     <= pend_idx;
                        multi <= pend_multi;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (ready) begin
                        if (rem_any) begin
                            A     <= rem_idx;
                            multi <= rem_multi;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_req_encoder4to2.sv
// Directed self-checking bench for req_encoder4to2 (edge-capture mode).
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_req_encoder4to2;

    logic       clk;
    logic       rst_n;
    logic [3:0] D;
    logic [1:0] A;
    logic       valid;
    logic       ready;
    logic       multi;
    logic       ovf;
    logic       clr;

    int n_assert;
    int n_fail;

    req_encoder4to2 #(.EDGE_MODE(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .A     (A),
        .valid (valid),
        .ready (ready),
        .multi (multi),
        .ovf   (ovf),
        .clr   (clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the full offer view in one call.
    task automatic chk_offer(input string tag, input logic v, input logic [1:0] a,
                             input logic m);
        chk({tag, "_valid"}, {3'b0, valid}, {3'b0, v});
        if (v) begin
            chk({tag, "_A"}, {2'b0, A}, {2'b0, a});
            chk({tag, "_multi"}, {3'b0, multi}, {3'b0, m});
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        D     = 4'b0000;
        ready = 1'b0;
        clr   = 1'b0;

        // Reset state
        #1;
        chk("rst_valid", {3'b0, valid}, 4'h0);
        chk("rst_A", {2'b0, A}, 4'h0);
        chk("rst_multi", {3'b0, multi}, 4'h0);
        chk("rst_ovf", {3'b0, ovf}, 4'h0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk_offer("idle", 1'b0, 2'd0, 1'b0);

        // Single request, ready held high (also ready while idle)
        D = 4'b0100; ready = 1'b1;
        tick(1);
        D = 4'b0000;
        chk_offer("single_e0", 1'b0, 2'd0, 1'b0);
        tick(1);
        chk_offer("single_e1", 1'b1, 2'd2, 1'b0);
        tick(1);
        chk_offer("single_e2", 1'b0, 2'd0, 1'b0);
        chk("single_ovf", {3'b0, ovf}, 4'h0);

        // Priority and back-to-back drain of 1011
        D = 4'b1011;
        tick(1);
        D = 4'b0000;
        chk_offer("b2b_e0", 1'b0, 2'd0, 1'b0);
        tick(1);
        chk_offer("b2b_a3", 1'b1, 2'd3, 1'b1);
        tick(1);
        chk_offer("b2b_a1", 1'b1, 2'd1, 1'b1);
        tick(1);
        chk_offer("b2b_a0", 1'b1, 2'd0, 1'b0);
        tick(1);
        chk_offer("b2b_end", 1'b0, 2'd0, 1'b0);

        // Priority on 0110
        D = 4'b0110;
        tick(1);
        D = 4'b0000;
        tick(1);
        chk_offer("p0110_a2", 1'b1, 2'd2, 1'b1);
        tick(1);
        chk_offer("p0110_a1", 1'b1, 2'd1, 1'b0);
        tick(1);
        chk_offer("p0110_end", 1'b0, 2'd0, 1'b0);

        // Backpressure with a higher-priority arrival mid-offer
        ready = 1'b0; D = 4'b0001;
        tick(1);
        D = 4'b0000;
        tick(1);
        chk_offer("bp_c1", 1'b1, 2'd0, 1'b0);
        tick(1);
        D = 4'b1000;
        tick(1);
        D = 4'b0000;
        chk_offer("bp_c3", 1'b1, 2'd0, 1'b0);
        tick(1);
        chk_offer("bp_c4", 1'b1, 2'd0, 1'b0);
        ready = 1'b1;
        tick(1);
        chk_offer("bp_a3", 1'b1, 2'd3, 1'b0);
        tick(1);
        chk_offer("bp_end", 1'b0, 2'd0, 1'b0);
        chk("bp_ovf", {3'b0, ovf}, 4'h0);

        // Overflow: second D[1] pulse while line 1 still pending
        ready = 1'b0; D = 4'b0010;
        tick(1);
        D = 4'b0000;
        tick(1);
        chk_offer("ovf_offer", 1'b1, 2'd1, 1'b0);
        chk("ovf_before", {3'b0, ovf}, 4'h0);
        D = 4'b0010;
        tick(1);
        D = 4'b0000;
        chk("ovf_set", {3'b0, ovf}, 4'h1);
        chk_offer("ovf_held", 1'b1, 2'd1, 1'b0);
        tick(2);
        chk("ovf_sticky", {3'b0, ovf}, 4'h1);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("clr_ovf", {3'b0, ovf}, 4'h0);
        chk("clr_valid", {3'b0, valid}, 4'h0);
        chk("clr_A", {2'b0, A}, 4'h0);
        chk("clr_multi", {3'b0, multi}, 4'h0);
        tick(2);
        chk_offer("clr_pend_empty", 1'b0, 2'd0, 1'b0);

        // Same-cycle re-request on the granted line
        D = 4'b0100;
        tick(1);
        D = 4'b0000;
        tick(1);
        chk_offer("rereq_offer", 1'b1, 2'd2, 1'b0);
        ready = 1'b1; D = 4'b0100;
        tick(1);
        D = 4'b0000;
        chk_offer("rereq_again", 1'b1, 2'd2, 1'b0);
        chk("rereq_ovf", {3'b0, ovf}, 4'h0);
        tick(1);
        chk_offer("rereq_end", 1'b0, 2'd0, 1'b0);

        // Reset mid-offer with D held through release
        ready = 1'b0; D = 4'b0010;
        tick(2);
        chk_offer("rmid_offer", 1'b1, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rmid_valid", {3'b0, valid}, 4'h0);
        chk("rmid_A", {2'b0, A}, 4'h0);
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk_offer("rmid_e0", 1'b0, 2'd0, 1'b0);
        tick(1);
        chk_offer("rmid_e1", 1'b1, 2'd1, 1'b0);
        chk("rmid_ovf", {3'b0, ovf}, 4'h0);
        ready = 1'b1;
        tick(1);
        chk_offer("rmid_end", 1'b0, 2'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
